// File: rtl/mcycle_unit_if.sv
// Core-side handshake and operand/result bundle for the iterative multiply/divide unit.
interface mcycle_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       MCycleOp;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [WIDTH-1:0] Result1;
  logic [WIDTH-1:0] Result2;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, MCycleOp, Operand1, Operand2,
    input  Result1, Result2, Busy, Done
  );

  modport slave (
    input  Start, MCycleOp, Operand1, Operand2,
    output Result1, Result2, Busy, Done
  );
endinterface

// File: rtl/mcycle_unit.sv
// Iterative shift-add multiplier / restoring divider, one iteration per cycle, with a Start/Busy/Done stall handshake.
// Optional macro MCYCLE_EARLY_TERM_EN lets MUL ops exit once the remaining multiplier bits are all zero.
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic         CLK,
  input  logic         RESET,
  mcycle_unit_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_COMPUTE = 2'b01;
  localparam logic [1:0] S_DONE    = 2'b10;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               div_zero;
  logic [WIDTH-1:0]   op1_raw;
  logic [WIDTH-1:0]   sh_b;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   res1;
  logic [WIDTH-1:0]   res2;

  logic signed [WIDTH-1:0] op1_s;
  logic signed [WIDTH-1:0] op2_s;
  logic                    op_signed;
  logic                    sign1;
  logic                    sign2;
  logic [WIDTH-1:0]        a_abs;
  logic [WIDTH-1:0]        b_abs;
  logic                    start_ok;

  assign op1_s     = bus.Operand1;
  assign op2_s     = bus.Operand2;
  assign op_signed = bus.MCycleOp[0];
  assign sign1     = op_signed && (op1_s < 0);
  assign sign2     = op_signed && (op2_s < 0);
  assign a_abs     = neg_w(bus.Operand1, sign1);
  assign b_abs     = neg_w(bus.Operand2, sign2);
  assign start_ok  = bus.Start && (state != S_COMPUTE);

  // One iteration of the selected algorithm, evaluated from the current working registers
  logic [2*WIDTH-1:0] acc_nxt;
  logic [2*WIDTH-1:0] mcand_nxt;
  logic [WIDTH-1:0]   sh_b_nxt;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     trial;

  always_comb begin
    acc_nxt   = acc;
    mcand_nxt = mcand;
    sh_b_nxt  = sh_b;
    rem_sh    = acc[2*WIDTH-1:WIDTH-1];
    trial     = rem_sh - {1'b0, sh_b};
    if (!is_div) begin
      if (sh_b[0]) acc_nxt = acc + mcand;
      mcand_nxt = mcand << 1;
      sh_b_nxt  = sh_b >> 1;
    end else if (!trial[WIDTH]) begin
      acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  logic early_exit;
`ifdef MCYCLE_EARLY_TERM_EN
  // Partial products accumulate against a left-shifting multiplicand, so no realignment is needed on exit
  assign early_exit = !is_div && (sh_b_nxt == '0);
`else
  assign early_exit = 1'b0;
`endif

  logic last_iter;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1)) || early_exit;

  logic [WIDTH-1:0] res1_nxt;
  logic [WIDTH-1:0] res2_nxt;

  always_comb begin
    res1_nxt = '0;
    res2_nxt = '0;
    if (is_div) begin
      res1_nxt = div_zero ? '1 : neg_w(acc_nxt[WIDTH-1:0], neg_q);
      res2_nxt = div_zero ? op1_raw : neg_w(acc_nxt[2*WIDTH-1:WIDTH], neg_r);
    end else begin
      {res2_nxt, res1_nxt} = neg_2w(acc_nxt, neg_q);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= S_IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      op1_raw  <= '0;
      sh_b     <= '0;
      acc      <= '0;
      mcand    <= '0;
      res1     <= '0;
      res2     <= '0;
    end else if (state == S_COMPUTE) begin
      acc   <= acc_nxt;
      mcand <= mcand_nxt;
      sh_b  <= sh_b_nxt;
      cnt   <= cnt + CNT_W'(1);
      if (last_iter) begin
        state <= S_DONE;
        res1  <= res1_nxt;
        res2  <= res2_nxt;
      end
    end else if (start_ok) begin
      state    <= S_COMPUTE;
      cnt      <= '0;
      is_div   <= bus.MCycleOp[1];
      neg_q    <= sign1 ^ sign2;
      neg_r    <= sign1;
      div_zero <= (bus.Operand2 == '0);
      op1_raw  <= bus.Operand1;
      sh_b     <= b_abs;
      // Divide keeps {remainder, dividend/quotient} in acc; multiply accumulates into it from zero
      if (bus.MCycleOp[1]) begin
        acc   <= {{WIDTH{1'b0}}, a_abs};
        mcand <= '0;
      end else begin
        acc   <= '0;
        mcand <= {{WIDTH{1'b0}}, a_abs};
      end
    end else begin
      state <= S_IDLE;
    end
  end

  assign bus.Busy    = (state == S_COMPUTE) || start_ok;
  assign bus.Done    = (state == S_DONE);
  assign bus.Result1 = res1;
  assign bus.Result2 = res2;
endmodule
